// File: rtl/motion_pkg.sv
// Shared definitions for the motion sequencer: opcode codes, FSM states and
// opcode validation.
package motion_pkg;

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_PVR  = 3'b001;
    localparam logic [2:0] OP_PVL  = 3'b010;
    localparam logic [2:0] OP_STOP = 3'b011;
    localparam logic [2:0] OP_SPIN = 3'b100;
    localparam logic [2:0] OP_REV  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BRAKE,
        S_RUN
    } fsm_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= OP_REV;
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command handshake bundle between the navigation logic and the sequencer.
interface motion_sequencer_if #(
    parameter int unsigned DUR_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [DUR_W-1:0] cmd_dur;

    modport master (output cmd_valid, output cmd_op, output cmd_dur, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_dur, output cmd_ready);
endinterface

// File: rtl/motion_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; occupancy counter separates full from empty.
module cmd_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/motion_sequencer.sv
// Plays queued timed motion commands out as wheel-decoder state codes, with a
// timed stop gap between differing back-to-back moves.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned DUR_W       = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BRAKE_TICKS = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    motion_sequencer_if.slave      cmd,
    input  logic                   abort,
    output logic [2:0]             state,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned BRK_W = (BRAKE_TICKS > 0) ? $clog2(BRAKE_TICKS + 1) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    fsm_t             fsm, fsm_nxt;
    logic [2:0]       op_r, prev_op, state_nxt, head_op;
    logic [DUR_W-1:0] rem_r, head_dur;
    logic [BRK_W-1:0] brk_r;
    logic             fire, push, pop, empty, full, done_nxt, brake_needed;

    assign fire = cmd.cmd_valid && cmd.cmd_ready;
    assign push = fire && op_valid(cmd.cmd_op) && !abort;
    assign pop  = (fsm == S_LOAD) && !abort;

    cmd_fifo #(.WIDTH(3 + DUR_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .din   ({cmd.cmd_op, cmd.cmd_dur}),
        .head  ({head_op, head_dur}),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    assign cmd.cmd_ready = !full;
    assign busy          = (fsm != S_IDLE) || !empty;
    assign tick          = (pre_cnt == PRE_W'(TICK_DIV - 1));
    // LOAD decides on the entry being popped, so compare against the FIFO head.
    assign brake_needed  = (BRAKE_TICKS != 0) && (prev_op != OP_STOP) && (prev_op != head_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= S_IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        unique case (fsm)
            S_IDLE:  if (!empty) fsm_nxt = S_LOAD;
            S_LOAD:  fsm_nxt = brake_needed ? S_BRAKE : S_RUN;
            S_BRAKE: if (brk_r == '0) fsm_nxt = S_RUN;
            S_RUN:   if (rem_r == '0) fsm_nxt = empty ? S_IDLE : S_LOAD;
            default: fsm_nxt = S_IDLE;
        endcase
        if (abort) fsm_nxt = S_IDLE;
    end

    // Outputs are registered from the next FSM state so they align with it.
    always_comb begin
        state_nxt = state;
        unique case (fsm_nxt)
            S_IDLE, S_BRAKE: state_nxt = OP_STOP;
            S_LOAD:          state_nxt = state;
            S_RUN:           state_nxt = (fsm == S_LOAD) ? head_op : op_r;
            default:         state_nxt = OP_STOP;
        endcase
        done_nxt = (fsm == S_RUN) && (rem_r == '0) && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OP_STOP;
            done    <= 1'b0;
            err     <= 1'b0;
            op_r    <= OP_STOP;
            prev_op <= OP_STOP;
            rem_r   <= '0;
            brk_r   <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= fire && !op_valid(cmd.cmd_op);
            if (abort) begin
                prev_op <= OP_STOP;
            end else begin
                if (fsm == S_LOAD) begin
                    op_r  <= head_op;
                    rem_r <= head_dur;
                    brk_r <= BRK_W'(BRAKE_TICKS);
                end
                if (fsm == S_BRAKE && tick && brk_r != '0) brk_r <= brk_r - 1'b1;
                if (fsm == S_RUN && tick && rem_r != '0) rem_r <= rem_r - 1'b1;
                if (done_nxt) prev_op <= op_r;
                if (fsm_nxt == S_IDLE && fsm != S_IDLE) prev_op <= OP_STOP;
            end
        end
    end
endmodule
